// File: rtl/bus_dpram_capture.sv
// Sample capture front-end for a DPRAM write port: one-shot or circular
// pre-trigger capture, with trigger/last address reporting and abort.
module bus_dpram_capture #(
  parameter int DEPTH = 256
) (
  input  logic        i_Bus_Clk,
  input  logic        i_Bus_Rst,
  input  logic        i_Data_DV,
  input  logic [15:0] i_Data,
  input  logic        i_Arm,
  input  logic        i_Trig,
  input  logic        i_Abort,
  input  logic        i_Circular,
  input  logic [15:0] i_Post_Count,
  output logic        o_Wr_DV,
  output logic [15:0] o_Wr_Addr,
  output logic [15:0] o_Wr_Data,
  output logic        o_Armed,
  output logic        o_Busy,
  output logic        o_Done,
  output logic        o_Wrapped,
  output logic [15:0] o_Trig_Addr,
  output logic [15:0] o_Last_Addr
);

  localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0]   ADDR_MAX = AW'(DEPTH - 1);
  localparam logic [16:0]     DEPTH_C  = 17'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            wrapped_q, wrapped_d;
  logic            circ_q, circ_d;
  logic [16:0]     target_q, target_d;
  logic [16:0]     cnt_q, cnt_d;
  logic            pend_q, pend_d;
  logic [AW-1:0]   trig_addr_q, trig_addr_d;
  logic [AW-1:0]   last_addr_q, last_addr_d;
  logic            wr_dv_q, wr_dv_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [15:0]     wr_data_q, wr_data_d;
  logic            accept;
  logic [16:0]     cnt_inc;

  always_ff @(posedge i_Bus_Clk) begin
    if (i_Bus_Rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wrapped_q   <= 1'b0;
      circ_q      <= 1'b0;
      target_q    <= '0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      trig_addr_q <= '0;
      last_addr_q <= '0;
      wr_dv_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wrapped_q   <= wrapped_d;
      circ_q      <= circ_d;
      target_q    <= target_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      trig_addr_q <= trig_addr_d;
      last_addr_q <= last_addr_d;
      wr_dv_q     <= wr_dv_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // Pre-trigger samples only land in circular mode; the trigger-cycle sample
  // is always taken. Abort suppresses the sample arriving with it.
  assign accept  = i_Data_DV && !i_Abort &&
                   ((state_q == S_ARMED && (circ_q || i_Trig)) || state_q == S_CAPTURE);
  assign cnt_inc = cnt_q + 17'd1;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wrapped_d   = wrapped_q;
    circ_d      = circ_q;
    target_d    = target_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    trig_addr_d = trig_addr_q;
    last_addr_d = last_addr_q;
    wr_dv_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    if (i_Abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (i_Arm) begin
            state_d   = S_ARMED;
            addr_d    = '0;
            wrapped_d = 1'b0;
            circ_d    = i_Circular;
            cnt_d     = '0;
            pend_d    = 1'b0;
            target_d  = (!i_Circular || i_Post_Count == 16'd0 ||
                         {1'b0, i_Post_Count} > DEPTH_C) ? DEPTH_C : {1'b0, i_Post_Count};
          end
        end
        S_ARMED: begin
          if (i_Trig) begin
            state_d = S_CAPTURE;
            pend_d  = !i_Data_DV;
            if (i_Data_DV) begin
              trig_addr_d = addr_q;
              cnt_d       = 17'd1;
              if (target_q == 17'd1) state_d = S_DONE;
            end
          end
        end
        S_CAPTURE: begin
          if (i_Data_DV) begin
            cnt_d  = cnt_inc;
            pend_d = 1'b0;
            if (pend_q) trig_addr_d = addr_q;
            if (cnt_inc == target_q) state_d = S_DONE;
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (accept) begin
        wr_dv_d     = 1'b1;
        wr_addr_d   = addr_q;
        wr_data_d   = i_Data;
        last_addr_d = addr_q;
        addr_d      = addr_q + AW'(1);
        if (addr_q == ADDR_MAX) wrapped_d = 1'b1;
      end
    end
  end

  assign o_Wr_DV     = wr_dv_q;
  assign o_Wr_Addr   = 16'(wr_addr_q);
  assign o_Wr_Data   = wr_data_q;
  assign o_Armed     = (state_q == S_ARMED);
  assign o_Busy      = (state_q == S_ARMED) || (state_q == S_CAPTURE);
  assign o_Done      = (state_q == S_DONE);
  assign o_Wrapped   = wrapped_q;
  assign o_Trig_Addr = 16'(trig_addr_q);
  assign o_Last_Addr = 16'(last_addr_q);

endmodule

// File: tb/tb_bus_dpram_capture.sv
// Bench for bus_dpram_capture: directed scenarios with literal expectations
// plus long randomized traffic against a cycle-level behavioural model.
module tb_bus_dpram_capture;
  localparam int DEPTH = 256;
  localparam int P_IDLE = 0, P_ARMED = 1, P_CAP = 2, P_DONE = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, dv, arm, trig, abort, circ;
  logic [15:0] data, post;
  logic        o_wr_dv, o_armed, o_busy, o_done, o_wrapped;
  logic [15:0] o_wr_addr, o_wr_data, o_trig_addr, o_last_addr;

  bus_dpram_capture #(.DEPTH(DEPTH)) dut (
    .i_Bus_Clk(clk), .i_Bus_Rst(rst), .i_Data_DV(dv), .i_Data(data),
    .i_Arm(arm), .i_Trig(trig), .i_Abort(abort), .i_Circular(circ),
    .i_Post_Count(post), .o_Wr_DV(o_wr_dv), .o_Wr_Addr(o_wr_addr),
    .o_Wr_Data(o_wr_data), .o_Armed(o_armed), .o_Busy(o_busy),
    .o_Done(o_done), .o_Wrapped(o_wrapped), .o_Trig_Addr(o_trig_addr),
    .o_Last_Addr(o_last_addr)
  );

  int vectors = 0, errs = 0, wr_cnt = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: phase, running address modulo DEPTH, post-trigger tally.
  int m_ph, m_addr, m_wrap, m_circ, m_target, m_cnt, m_pend;
  int m_trig, m_last, m_wdv, m_waddr, m_wdata;
  bit m_acc;

  always @(posedge clk) begin
    if (rst) begin
      m_ph = P_IDLE; m_addr = 0; m_wrap = 0; m_circ = 0; m_target = 0; m_cnt = 0;
      m_pend = 0; m_trig = 0; m_last = 0; m_wdv = 0; m_waddr = 0; m_wdata = 0;
    end else begin
      m_acc = dv && !abort && ((m_ph == P_ARMED && (m_circ != 0 || trig)) || m_ph == P_CAP);
      m_wdv = 0;
      if (abort) m_ph = P_IDLE;
      else if (arm && (m_ph == P_IDLE || m_ph == P_DONE)) begin
        m_ph = P_ARMED; m_addr = 0; m_wrap = 0; m_circ = circ; m_cnt = 0; m_pend = 0;
        m_target = (!circ || post == 0 || int'(post) > DEPTH) ? DEPTH : int'(post);
      end else if (m_ph == P_ARMED && trig) begin
        m_ph = P_CAP; m_cnt = m_acc ? 1 : 0; m_pend = m_acc ? 0 : 1;
        if (m_acc) m_trig = m_addr;
      end else if (m_ph == P_CAP && m_acc) begin
        m_cnt++;
        if (m_pend != 0) m_trig = m_addr;
        m_pend = 0;
      end
      if (m_acc) begin
        m_wdv = 1; m_waddr = m_addr; m_wdata = int'(data); m_last = m_addr;
        if (m_addr == DEPTH - 1) m_wrap = 1;
        m_addr = (m_addr + 1) % DEPTH;
        if (m_ph == P_CAP && m_cnt == m_target) m_ph = P_DONE;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("wr_dv", o_wr_dv, m_wdv);
      check("wr_addr", o_wr_addr, m_waddr);
      check("wr_data", o_wr_data, m_wdata);
      check("armed", o_armed, m_ph == P_ARMED);
      check("busy", o_busy, m_ph == P_ARMED || m_ph == P_CAP);
      check("done", o_done, m_ph == P_DONE);
      check("wrapped", o_wrapped, m_wrap);
      check("trig_addr", o_trig_addr, m_trig);
      check("last_addr", o_last_addr, m_last);
    end
  end

  always @(negedge clk) if (o_wr_dv === 1'b1) wr_cnt++;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cyc(input bit d, input logic [15:0] v, input bit a, input bit t, input bit ab);
    dv = d; data = v; arm = a; trig = t; abort = ab;
    tick();
    dv = 0; arm = 0; trig = 0; abort = 0;
  endtask

  int base;

  initial begin
    rst = 1; dv = 0; arm = 0; trig = 0; abort = 0; circ = 0; data = 0; post = 0;
    tick(); chk_en = 1'b1; tick();
    check("rst_outs", {o_wr_dv, o_armed, o_busy, o_done, o_wrapped}, 0);
    check("rst_addrs", {o_wr_addr, o_trig_addr}, 0);
    rst = 0;

    // Idle trigger and one-shot pre-trigger samples are dropped
    base = wr_cnt;
    for (int i = 0; i < 4; i++) cyc(1, 16'hAA00 + 16'(i), 0, 1, 0);
    check("idle_nowr", wr_cnt - base, 0);
    check("idle_armed", o_armed, 0);
    circ = 0; cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 16'hBB00 + 16'(i), 0, 0, 0);
    tick();
    check("oneshot_pre_nowr", wr_cnt - base, 0);
    check("oneshot_armed", o_armed, 1);
    cyc(0, 0, 0, 0, 1);

    // One-shot full buffer
    circ = 0; cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0);
    for (int n = 0; n < 256; n++) cyc(1, 16'h1000 + 16'(n), 0, 0, 0);
    check("os_last_wr", {o_wr_dv, o_wr_addr, o_wr_data}, {1'b1, 16'd255, 16'h10FF});
    check("os_done", o_done, 1);
    check("os_trig", o_trig_addr, 0);
    check("os_last", o_last_addr, 255);
    check("os_wrap", o_wrapped, 1);

    // Circular pre-trigger, post count 8
    circ = 1; post = 8; cyc(0, 0, 1, 0, 0);
    for (int n = 0; n < 300; n++) cyc(1, 16'(n), 0, 0, 0);
    cyc(1, 16'hC0DE, 0, 1, 0);
    check("circ_trig_wr", {o_wr_addr, o_wr_data}, {16'd44, 16'hC0DE});
    check("circ_trig", o_trig_addr, 44);
    for (int n = 0; n < 7; n++) cyc(1, 16'h2000 + 16'(n), 0, 0, 0);
    check("circ_done", o_done, 1);
    check("circ_last", o_last_addr, 51);
    check("circ_wrap", o_wrapped, 1);

    // Abort after 10 capture samples, with a sample in the abort cycle
    circ = 0; cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0);
    base = wr_cnt;
    for (int n = 0; n < 10; n++) cyc(1, 16'h3000 + 16'(n), 0, 0, 0);
    cyc(1, 16'h3FFF, 0, 0, 1);
    tick();
    check("abort_wrs", wr_cnt - base, 10);
    check("abort_state", {o_armed, o_busy, o_done}, 0);

    // Reset mid-capture then restart
    circ = 0; cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0);
    for (int n = 0; n < 5; n++) cyc(1, 16'h4000 + 16'(n), 0, 0, 0);
    rst = 1; cyc(1, 16'h4444, 0, 0, 0); rst = 0;
    check("midrst_outs", {o_wr_dv, o_armed, o_busy, o_done, o_wrapped}, 0);
    check("midrst_addrs", {o_wr_addr, o_wr_data, o_trig_addr, o_last_addr}, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(1, 16'h5A5A, 0, 1, 0);
    check("restart_wr", {o_wr_dv, o_wr_addr, o_wr_data}, {1'b1, 16'd0, 16'h5A5A});

    // Circular with post count 0 behaves as DEPTH
    cyc(0, 0, 0, 0, 1);
    circ = 1; post = 0; cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0);
    for (int n = 0; n < 255; n++) cyc(1, 16'(n), 0, 0, 0);
    check("pc0_notdone", o_done, 0);
    cyc(1, 16'hFFFF, 0, 0, 0);
    check("pc0_done", o_done, 1);

    // Randomized traffic
    for (int i = 0; i < 30000; i++) begin
      dv    = 1'($urandom_range(0, 1));
      data  = 16'($urandom);
      arm   = ($urandom_range(0, 99) == 0);
      trig  = ($urandom_range(0, 39) == 0);
      abort = ($urandom_range(0, 499) == 0);
      rst   = ($urandom_range(0, 3999) == 0);
      circ  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 6))
        0: post = 16'd0;
        1: post = 16'd1;
        2: post = 16'($urandom_range(2, 40));
        3: post = 16'd255;
        4: post = 16'd256;
        5: post = 16'd257;
        default: post = 16'hFFFF;
      endcase
      tick();
    end
    rst = 0; dv = 0; arm = 0; trig = 0; abort = 0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
